// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS checker.
// Optional feature macro used by the checker: PRBS_CHK_BIT_COUNT_EN.
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int         DEFAULT_N    = 3;
    localparam logic [3:0] DEFAULT_TAPS = 4'b1011;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
        return (val >= max_v) ? max_v : (val + 32'd1);
    endfunction

endpackage

// File: rtl/prbs_predictor.sv
// History shift register and tap-XOR predictor for the PRBS checker.
// Shifts in either the received bit (while searching) or its own prediction (while locked).
module prbs_predictor
    import prbs_pkg::*;
#(
    parameter int         N    = DEFAULT_N,
    parameter logic [N:0] TAPS = DEFAULT_TAPS
) (
    input  logic clk,
    input  logic reset,
    input  logic shift_en,
    input  logic sel_pred,
    input  logic in_bit,
    output logic pred,
    output logic hist_zero
);

    logic [N:0] hist_q;
    logic [N:0] hist_d;

    assign pred      = ^(hist_q & TAPS);
    assign hist_zero = (hist_q == '0);

    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d = {hist_q[N-1:0], (sel_pred ? pred : in_bit)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: locks to an LFSR stream, then counts bit errors against a local reference.
// Define PRBS_CHK_BIT_COUNT_EN to add the bit_count port and its saturating counter.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int         N        = DEFAULT_N,
    parameter logic [N:0] TAPS     = DEFAULT_TAPS,
    parameter int         LOCK_CNT = 8,
    parameter int         LOSS_CNT = 4,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             err_pulse,
    output logic             lost_lock,
    output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHK_BIT_COUNT_EN
    ,
    output logic [CNT_W-1:0] bit_count
`endif
);

    localparam int FILL_W  = $clog2(N + 2);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    localparam logic [FILL_W-1:0]  FILL_DONE   = FILL_W'(N + 1);
    localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  LOSS_TARGET = MISS_W'(LOSS_CNT);

    state_e             state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d, match_inc;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d, miss_inc;
    logic               err_pulse_q, err_pulse_d;
    logic               lost_lock_q, lost_lock_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               pred;
    logic               hist_zero;

    prbs_predictor #(
        .N    (N),
        .TAPS (TAPS)
    ) u_predictor (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (in_valid),
        .sel_pred  (state_q == LOCKED),
        .in_bit    (in_bit),
        .pred      (pred),
        .hist_zero (hist_zero)
    );

    assign match_inc = match_cnt_q + 1'b1;
    assign miss_inc  = miss_cnt_q + 1'b1;

`ifdef PRBS_CHK_BIT_COUNT_EN
    logic [CNT_W-1:0] bit_count_q, bit_count_d;

    always_comb begin
        bit_count_d = bit_count_q;
        if (in_valid && (state_q == LOCKED)) begin
            bit_count_d = CNT_W'(sat_inc(32'(bit_count_q), CNT_W));
        end
        if (clear) begin
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_count_q <= '0;
        end else begin
            bit_count_q <= bit_count_d;
        end
    end

    assign bit_count = bit_count_q;
`endif

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        lost_lock_d = 1'b0;
        err_count_d = err_count_q;
        if (in_valid) begin
            if (state_q == SEARCH) begin
                if (fill_q != FILL_DONE) begin
                    fill_d = fill_q + 1'b1;
                end else if ((in_bit == pred) && !hist_zero) begin
                    // An all-zero history predicts zero forever; refuse it as a match.
                    match_cnt_d = match_inc;
                    if (match_inc == LOCK_TARGET) begin
                        state_d = LOCKED;
                    end
                end else begin
                    match_cnt_d = '0;
                end
            end else begin
                if (in_bit != pred) begin
                    err_pulse_d = 1'b1;
                    err_count_d = CNT_W'(sat_inc(32'(err_count_q), CNT_W));
                    miss_cnt_d  = miss_inc;
                    if (miss_inc == LOSS_TARGET) begin
                        state_d     = SEARCH;
                        fill_d      = '0;
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                        lost_lock_d = 1'b1;
                    end
                end else begin
                    miss_cnt_d = '0;
                end
            end
        end
        if (clear) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            fill_q      <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
            lost_lock_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_pulse_q <= err_pulse_d;
            lost_lock_q <= lost_lock_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign lost_lock = lost_lock_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: vector table, directed corner sequences, random stream vs model.
module tb_prbs_checker;

    localparam int         N        = 3;
    localparam logic [3:0] TAPS     = 4'b1011;
    localparam int         LOCK_CNT = 8;
    localparam int         LOSS_CNT = 4;
    localparam int         CW       = 4;
    localparam int         MAXC     = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic          lost_lock;
    logic [CW-1:0] err_count;
`ifdef PRBS_CHK_BIT_COUNT_EN
    logic [CW-1:0] bit_count;
`endif

    prbs_checker #(
        .N        (N),
        .TAPS     (TAPS),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .locked    (locked),
        .err_pulse (err_pulse),
        .lost_lock (lost_lock),
        .err_count (err_count)
`ifdef PRBS_CHK_BIT_COUNT_EN
        ,
        .bit_count (bit_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int g = 0;

    // Reference model: recent received/predicted bits kept newest-first in a queue.
    bit m_hist[$];
    int m_fill, m_match, m_miss, m_err, m_bits;
    bit m_locked, m_pulse, m_lost;

    function automatic bit next_good();
        bit r;
        r = pat[g % 7];
        g++;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = {};
        for (int k = 0; k <= N; k++) m_hist.push_back(1'b0);
        m_fill = 0; m_match = 0; m_miss = 0; m_err = 0; m_bits = 0;
        m_locked = 0; m_pulse = 0; m_lost = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit c);
        bit p;
        bit nonzero;
        m_pulse = 0;
        m_lost  = 0;
        if (v) begin
            p = 0;
            nonzero = 0;
            for (int k = 0; k <= N; k++) begin
                if (TAPS[k]) p ^= m_hist[k];
                if (m_hist[k]) nonzero = 1;
            end
            if (!m_locked) begin
                if (m_fill < N + 1) begin
                    m_fill++;
                end else if (b == p && nonzero) begin
                    m_match++;
                    if (m_match == LOCK_CNT) m_locked = 1;
                end else begin
                    m_match = 0;
                end
                m_hist.push_front(b);
            end else begin
                m_bits = (m_bits == MAXC) ? MAXC : m_bits + 1;
                if (b != p) begin
                    m_pulse = 1;
                    m_err = (m_err == MAXC) ? MAXC : m_err + 1;
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin
                        m_locked = 0; m_fill = 0; m_match = 0; m_miss = 0; m_lost = 1;
                    end
                end else begin
                    m_miss = 0;
                end
                m_hist.push_front(p);
            end
            void'(m_hist.pop_back());
        end
        if (c) begin
            m_err  = 0;
            m_bits = 0;
        end
    endtask

    task automatic check_model();
        check("m_locked", int'(locked), int'(m_locked));
        check("m_err_pulse", int'(err_pulse), int'(m_pulse));
        check("m_lost_lock", int'(lost_lock), int'(m_lost));
        check("m_err_count", int'(err_count), m_err);
`ifdef PRBS_CHK_BIT_COUNT_EN
        check("m_bit_count", int'(bit_count), m_bits);
`endif
    endtask

    task automatic step(input bit v, input bit b, input bit c);
        @(negedge clk);
        in_valid = v; in_bit = b; clear = c;
        @(posedge clk);
        model_step(v, b, c);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; in_valid = 0; clear = 0;
        @(posedge clk);
        model_reset();
        #1;
        check_model();
        check("rst_locked", int'(locked), 0);
        check("rst_err_count", int'(err_count), 0);
        @(negedge clk);
        reset = 0;
        g = 0;
    endtask

    typedef struct {
        bit rst;
        bit v;
        bit b;
        bit exp_locked;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        int nv;
        int saw;
        int pulses;
        int burst;
        bit b;

        // Continuous stream, then the same stream with in_valid toggling.
        for (int i = 0; i < 20; i++) begin
            e.rst = (i == 0); e.v = 1; e.b = pat[i % 7];
            e.exp_locked = ((i + 1) >= 12);
            tbl.push_back(e);
        end
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            e.rst = (i == 0);
            e.v = (i % 2 == 0);
            if (e.v) begin
                e.b = pat[nv % 7];
                nv++;
            end else begin
                e.b = 1'($urandom);
            end
            e.exp_locked = (nv >= 12);
            tbl.push_back(e);
        end

        model_reset();
        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].v, tbl[i].b, 0);
            check("tbl_locked", int'(locked), int'(tbl[i].exp_locked));
            check("tbl_err_count", int'(err_count), 0);
        end

        // 200 good bits: locked, no errors; then a single flipped bit.
        do_reset();
        for (int i = 0; i < 200; i++) step(1, next_good(), 0);
        check("t1_locked", int'(locked), 1);
        check("t1_err_count", int'(err_count), 0);
        step(1, ~next_good(), 0);
        check("t2_err_pulse", int'(err_pulse), 1);
        check("t2_err_count", int'(err_count), 1);
        check("t2_locked", int'(locked), 1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, next_good(), 0);
            pulses += int'(err_pulse);
        end
        check("t2_extra_pulses", pulses, 0);
        check("t2_err_count_hold", int'(err_count), 1);

        // All-zero input never locks.
        do_reset();
        saw = 0;
        for (int i = 0; i < 64; i++) begin
            step(1, 0, 0);
            saw |= int'(locked);
        end
        check("t4_never_locked", saw, 0);
        check("t4_err_count", int'(err_count), 0);

        // Loss of lock after LOSS_CNT consecutive errors, then relock.
        do_reset();
        for (int i = 0; i < 12; i++) step(1, next_good(), 0);
        check("t5_locked", int'(locked), 1);
        for (int k = 0; k < 4; k++) begin
            step(1, ~next_good(), 0);
            if (k < 3) check("t5_still_locked", int'(locked), 1);
        end
        check("t5_err_count", int'(err_count), 4);
        check("t5_lost_lock", int'(lost_lock), 1);
        check("t5_unlocked", int'(locked), 0);
        step(1, next_good(), 0);
        check("t5_lost_pulse_end", int'(lost_lock), 0);
        for (int i = 0; i < 10; i++) step(1, next_good(), 0);
        check("t5_not_yet_relocked", int'(locked), 0);
        step(1, next_good(), 0);
        check("t5_relocked", int'(locked), 1);
        check("t5_err_retained", int'(err_count), 4);

        // Saturation with isolated errors, then clear colliding with an error.
        do_reset();
        for (int i = 0; i < 12; i++) step(1, next_good(), 0);
        for (int e2 = 0; e2 < 20; e2++) begin
            step(1, ~next_good(), 0);
            for (int i = 0; i < 3; i++) step(1, next_good(), 0);
        end
        check("t6_err_sat", int'(err_count), 15);
        check("t6_locked", int'(locked), 1);
`ifdef PRBS_CHK_BIT_COUNT_EN
        check("t6_bit_sat", int'(bit_count), 15);
`endif
        step(1, ~next_good(), 1);
        check("t6_clear_wins", int'(err_count), 0);
        check("t6_clear_pulse", int'(err_pulse), 1);
        step(1, ~next_good(), 0);
        check("t6_count_after_clear", int'(err_count), 1);
        step(1, next_good(), 0);

        // Random stream with error bursts, phase slips, gaps and clears.
        do_reset();
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 4) != 0) begin
                b = next_good();
                if (burst > 0) begin
                    b = ~b;
                    burst--;
                end else if (($urandom % 40) == 0) begin
                    burst = $urandom_range(1, 5);
                end
                if (($urandom % 500) == 0) g++;
                step(1, b, (($urandom % 100) == 0));
            end else begin
                step(0, 1'($urandom), (($urandom % 100) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
